// File: rtl/id_remap_allocator.sv
// ID remapping allocator: binds each in-flight original ID to a row of a slot matrix
// and hands out unique IDs {row,col}; frees return the original ID one cycle later.
module id_remap_allocator #(
  parameter int ID_WIDTH        = 16,
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int MAX_OUTSTANDING = NUM_ROWS * NUM_COLS,
  localparam int ROW_W = $clog2(NUM_ROWS),
  localparam int COL_W = $clog2(NUM_COLS),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [ID_WIDTH-1:0] alloc_orig_id,
  output logic                alloc_ready,
  output logic [ID_WIDTH-1:0] alloc_uid,
  input  logic                free_valid,
  input  logic [ID_WIDTH-1:0] free_uid,
  output logic                free_resp_valid,
  output logic [ID_WIDTH-1:0] free_restored_id,
  output logic                free_err,
  output logic [CNT_W-1:0]    occupancy,
  output logic                empty,
  output logic                full
);

  localparam int RC_W = $clog2(NUM_COLS + 1);

  if (ROW_W + COL_W > ID_WIDTH) begin : g_bad_id_width
    $error("id_remap_allocator: ROW_W+COL_W exceeds ID_WIDTH");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_ROWS * NUM_COLS) begin : g_bad_cap
    $error("id_remap_allocator: MAX_OUTSTANDING out of range");
  end

  logic [NUM_ROWS-1:0]                             row_bound_q, row_bound_d;
  logic [NUM_ROWS-1:0][ID_WIDTH-1:0]               row_id_q, row_id_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]               busy_q, busy_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][ID_WIDTH-1:0] slot_id_q, slot_id_d;
  logic [NUM_ROWS-1:0][RC_W-1:0]                   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]                                occ_q, occ_d;
  logic                                            empty_q, empty_d;
  logic                                            full_q, full_d;
  logic                                            resp_valid_q, resp_valid_d;
  logic                                            resp_err_q, resp_err_d;
  logic [ID_WIDTH-1:0]                             resp_id_q, resp_id_d;

  logic             hit_s, any_unbound_s, grant_s, free_ok_s;
  logic [ROW_W-1:0] hit_row_s, new_row_s, sel_row_s, free_row_s;
  logic [COL_W-1:0] sel_col_s, free_col_s;
  logic [NUM_ROWS-1:0] grant_row_s, free_row_hit_s;
  logic             free_uid_unused_s;

  assign free_row_s        = free_uid[ROW_W+COL_W-1:COL_W];
  assign free_col_s        = free_uid[COL_W-1:0];
  assign free_uid_unused_s = ^free_uid;

  // Row/column selection from pre-free state; descending scans leave the lowest index.
  always_comb begin
    hit_s         = 1'b0;
    hit_row_s     = '0;
    any_unbound_s = 1'b0;
    new_row_s     = '0;
    sel_col_s     = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      hit_s         = hit_s | (row_bound_q[r] && (row_id_q[r] == alloc_orig_id));
      hit_row_s     = (row_bound_q[r] && (row_id_q[r] == alloc_orig_id)) ? ROW_W'(r) : hit_row_s;
      any_unbound_s = any_unbound_s | !row_bound_q[r];
      new_row_s     = !row_bound_q[r] ? ROW_W'(r) : new_row_s;
    end
    sel_row_s = hit_s ? hit_row_s : new_row_s;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      sel_col_s = !busy_q[sel_row_s][c] ? COL_W'(c) : sel_col_s;
    end
  end

  assign alloc_ready = !rst && !full_q &&
                       (hit_s ? (row_cnt_q[hit_row_s] < RC_W'(NUM_COLS)) : any_unbound_s);
  assign alloc_uid   = ID_WIDTH'({sel_row_s, sel_col_s});
  assign grant_s     = alloc_valid && alloc_ready;
  assign free_ok_s   = free_valid && busy_q[free_row_s][free_col_s];

  // Next-state for the slot matrix, row bindings and counters.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      grant_row_s[r]    = grant_s && (sel_row_s == ROW_W'(r));
      free_row_hit_s[r] = free_ok_s && (free_row_s == ROW_W'(r));
      row_cnt_d[r] = row_cnt_q[r] + (grant_row_s[r] ? RC_W'(1) : RC_W'(0))
                                  - (free_row_hit_s[r] ? RC_W'(1) : RC_W'(0));
      // A same-cycle grant into the row keeps it bound even if its last slot is freed.
      if (grant_row_s[r]) begin
        row_bound_d[r] = 1'b1;
        row_id_d[r]    = alloc_orig_id;
      end else if (free_row_hit_s[r] && (row_cnt_q[r] == RC_W'(1))) begin
        row_bound_d[r] = 1'b0;
        row_id_d[r]    = '0;
      end else begin
        row_bound_d[r] = row_bound_q[r];
        row_id_d[r]    = row_id_q[r];
      end
      for (int c = 0; c < NUM_COLS; c++) begin
        busy_d[r][c] = (grant_row_s[r] && (sel_col_s == COL_W'(c))) ? 1'b1 :
                       (free_row_hit_s[r] && (free_col_s == COL_W'(c))) ? 1'b0 : busy_q[r][c];
        slot_id_d[r][c] = (grant_row_s[r] && (sel_col_s == COL_W'(c))) ? alloc_orig_id
                                                                        : slot_id_q[r][c];
      end
    end
    occ_d        = occ_q + (grant_s ? CNT_W'(1) : CNT_W'(0)) - (free_ok_s ? CNT_W'(1) : CNT_W'(0));
    empty_d      = (occ_d == CNT_W'(0));
    full_d       = (occ_d == CNT_W'(MAX_OUTSTANDING));
    resp_valid_d = free_valid;
    resp_id_d    = free_ok_s ? slot_id_q[free_row_s][free_col_s] : '0;
    resp_err_d   = free_valid && !free_ok_s;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_bound_q  <= '0;
      row_id_q     <= '0;
      busy_q       <= '0;
      slot_id_q    <= '0;
      row_cnt_q    <= '0;
      occ_q        <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      row_bound_q  <= row_bound_d;
      row_id_q     <= row_id_d;
      busy_q       <= busy_d;
      slot_id_q    <= slot_id_d;
      row_cnt_q    <= row_cnt_d;
      occ_q        <= occ_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign free_resp_valid  = resp_valid_q;
  assign free_restored_id = resp_id_q;
  assign free_err         = resp_err_q;
  assign occupancy        = occ_q;
  assign empty            = empty_q;
  assign full             = full_q;

endmodule

// File: tb/tb_id_remap_allocator.sv
// Directed self-checking bench for id_remap_allocator (4x4 matrix, global cap of 6).
module tb_id_remap_allocator;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [15:0] alloc_orig_id;
  logic        alloc_ready;
  logic [15:0] alloc_uid;
  logic        free_valid;
  logic [15:0] free_uid;
  logic        free_resp_valid;
  logic [15:0] free_restored_id;
  logic        free_err;
  logic [2:0]  occupancy;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  id_remap_allocator #(
    .ID_WIDTH(16), .NUM_ROWS(4), .NUM_COLS(4), .MAX_OUTSTANDING(6)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_orig_id(alloc_orig_id),
    .alloc_ready(alloc_ready), .alloc_uid(alloc_uid),
    .free_valid(free_valid), .free_uid(free_uid),
    .free_resp_valid(free_resp_valid), .free_restored_id(free_restored_id),
    .free_err(free_err), .occupancy(occupancy), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input string tag, input logic [15:0] id, input logic [15:0] exp_uid);
    alloc_valid   = 1'b1;
    alloc_orig_id = id;
    #1;
    chk({tag, ".ready"}, 32'(alloc_ready), 32'd1);
    chk({tag, ".uid"}, 32'(alloc_uid), 32'(exp_uid));
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic do_free(input logic [15:0] uid);
    free_valid = 1'b1;
    free_uid   = uid;
    step();
    free_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_orig_id = 16'h0000;
    free_valid = 1'b0; free_uid = 16'h0000;
    #1;
    chk("rst.ready", 32'(alloc_ready), 32'd0);
    chk("rst.occ", 32'(occupancy), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.resp_valid", 32'(free_resp_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst.ready", 32'(alloc_ready), 32'd1);

    // Same-ID fill
    do_alloc("t1.a0", 16'h00A5, 16'h0000);
    do_alloc("t1.a1", 16'h00A5, 16'h0001);
    do_alloc("t1.a2", 16'h00A5, 16'h0002);
    chk("t1.occ", 32'(occupancy), 32'd3);
    chk("t1.empty", 32'(empty), 32'd0);

    // New ID, free, lowest-free reuse
    do_alloc("t2.new", 16'h1234, 16'h0004);
    chk("t2.occ4", 32'(occupancy), 32'd4);
    do_free(16'h0001);
    chk("t2.resp_valid", 32'(free_resp_valid), 32'd1);
    chk("t2.restored", 32'(free_restored_id), 32'h00A5);
    chk("t2.err", 32'(free_err), 32'd0);
    chk("t2.occ3", 32'(occupancy), 32'd3);
    do_alloc("t2.reuse", 16'h00A5, 16'h0001);
    chk("t2.resp_drop", 32'(free_resp_valid), 32'd0);
    chk("t2.occ_end", 32'(occupancy), 32'd4);

    // Row-full stall
    do_reset();
    do_alloc("t3.a0", 16'h0007, 16'h0000);
    do_alloc("t3.a1", 16'h0007, 16'h0001);
    do_alloc("t3.a2", 16'h0007, 16'h0002);
    do_alloc("t3.a3", 16'h0007, 16'h0003);
    alloc_valid = 1'b1; alloc_orig_id = 16'h0007;
    #1;
    chk("t3.held_ready", 32'(alloc_ready), 32'd0);
    step();
    chk("t3.held_occ", 32'(occupancy), 32'd4);
    chk("t3.held_ready2", 32'(alloc_ready), 32'd0);
    free_valid = 1'b1; free_uid = 16'h0002;
    #1;
    chk("t3.free_cycle_ready", 32'(alloc_ready), 32'd0);
    step();
    free_valid = 1'b0;
    #1;
    chk("t3.resp_restored", 32'(free_restored_id), 32'h0007);
    chk("t3.occ_after_free", 32'(occupancy), 32'd3);
    chk("t3.ready_after", 32'(alloc_ready), 32'd1);
    chk("t3.uid_after", 32'(alloc_uid), 32'h0002);
    step();
    alloc_valid = 1'b0;
    chk("t3.occ_end", 32'(occupancy), 32'd4);

    // Global cap with simultaneous alloc and free
    do_reset();
    do_alloc("t4.a0", 16'h000A, 16'h0000);
    do_alloc("t4.a1", 16'h000A, 16'h0001);
    do_alloc("t4.a2", 16'h000A, 16'h0002);
    do_alloc("t4.a3", 16'h000A, 16'h0003);
    do_alloc("t4.b0", 16'h000B, 16'h0004);
    do_alloc("t4.b1", 16'h000B, 16'h0005);
    chk("t4.full", 32'(full), 32'd1);
    chk("t4.occ6", 32'(occupancy), 32'd6);
    alloc_valid = 1'b1; alloc_orig_id = 16'h000C;
    free_valid = 1'b1; free_uid = 16'h0004;
    #1;
    chk("t4.cap_ready", 32'(alloc_ready), 32'd0);
    step();
    free_valid = 1'b0;
    #1;
    chk("t4.restored", 32'(free_restored_id), 32'h000B);
    chk("t4.occ5", 32'(occupancy), 32'd5);
    chk("t4.full_clear", 32'(full), 32'd0);
    chk("t4.ready_next", 32'(alloc_ready), 32'd1);
    chk("t4.uid_next", 32'(alloc_uid), 32'h0008);
    step();
    alloc_valid = 1'b0;
    chk("t4.occ_end", 32'(occupancy), 32'd6);
    chk("t4.full_end", 32'(full), 32'd1);

    // Illegal free, then last-slot free alongside a same-ID grant
    do_reset();
    do_free(16'h000F);
    chk("t5.ill_valid", 32'(free_resp_valid), 32'd1);
    chk("t5.ill_err", 32'(free_err), 32'd1);
    chk("t5.ill_restored", 32'(free_restored_id), 32'd0);
    chk("t5.ill_occ", 32'(occupancy), 32'd0);
    do_alloc("t5.first", 16'h0033, 16'h0000);
    free_valid = 1'b1; free_uid = 16'h0000;
    do_alloc("t5.same_cycle", 16'h0033, 16'h0001);
    free_valid = 1'b0;
    chk("t5.last_restored", 32'(free_restored_id), 32'h0033);
    chk("t5.last_err", 32'(free_err), 32'd0);
    chk("t5.last_occ", 32'(occupancy), 32'd1);
    do_alloc("t5.other_id", 16'h0044, 16'h0004);
    do_alloc("t5.fill0", 16'h0033, 16'h0000);
    do_alloc("t5.fill2", 16'h0033, 16'h0002);
    do_alloc("t5.fill3", 16'h0033, 16'h0003);
    alloc_valid = 1'b1; alloc_orig_id = 16'h0033;
    #1;
    chk("t5.row_cnt_stall", 32'(alloc_ready), 32'd0);
    alloc_valid = 1'b0;
    chk("t5.occ5", 32'(occupancy), 32'd5);

    // Reset mid-operation with a free in flight
    free_valid = 1'b1; free_uid = 16'h0002;
    #3;
    rst = 1'b1;
    #1;
    chk("t6.occ", 32'(occupancy), 32'd0);
    chk("t6.empty", 32'(empty), 32'd1);
    chk("t6.resp_valid", 32'(free_resp_valid), 32'd0);
    chk("t6.ready", 32'(alloc_ready), 32'd0);
    step();
    free_valid = 1'b0;
    step();
    chk("t6.resp_hold", 32'(free_resp_valid), 32'd0);
    rst = 1'b0;
    do_alloc("t6.realloc", 16'h00A5, 16'h0000);
    chk("t6.occ_end", 32'(occupancy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
